// File: rtl/simd_pkg.sv
// Shared SIMD definitions: matrix size codes, the dim / element-count lookup,
// FSM state encoding and the data-memory address width.
package simd_pkg;

  localparam int ADDR_W = 17;  // data-memory address width
  localparam int DATA_W = 8;   // matrix element width
  localparam int IDX_W  = 8;   // element index, up to 16*16-1
  localparam int RC_W   = 4;   // row / column index width

  typedef enum logic [1:0] {
    DIM_2X2   = 2'd0,
    DIM_4X4   = 2'd1,
    DIM_8X8   = 2'd2,
    DIM_16X16 = 2'd3
  } dimen_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

  // Side length of the square matrix for a size code.
  function automatic logic [4:0] dim_of(dimen_e code);
    logic [4:0] dim;
    unique case (code)
      DIM_2X2:   dim = 5'd2;
      DIM_4X4:   dim = 5'd4;
      DIM_8X8:   dim = 5'd8;
      DIM_16X16: dim = 5'd16;
      default:   dim = 5'd2;
    endcase
    return dim;
  endfunction

  // Element count N = dim*dim (4..256).
  function automatic logic [8:0] n_of(dimen_e code);
    return 9'(dim_of(code)) * 9'(dim_of(code));
  endfunction

endpackage

// File: rtl/data_fetch_load_if.sv
// Bundle of the fetch unit's control, data-memory and PE-buffer signals.
//   master : the fetch unit (drives memory read and PE write strobes)
//   slave  : control unit / memory / PE side (drives request and read data)
interface data_fetch_load_if;
  import simd_pkg::*;

  logic              ADDR_START;  // load request, held until FETCH_DONE
  logic              ADDR_RST;    // abort / clear pulse
  logic [ADDR_W-1:0] ADDRESS;     // matrix base address
  logic [1:0]        DIMEN;       // size code
  logic              MEM_RDEN;    // memory read enable
  logic [ADDR_W-1:0] MEM_ADDR;    // memory read address
  logic [DATA_W-1:0] MEM_RDATA;   // read data, one cycle after MEM_RDEN
  logic              PE_WREN;     // PE element write strobe
  logic [DATA_W-1:0] PE_DATA;     // element value
  logic [RC_W-1:0]   PE_ROW;      // element row
  logic [RC_W-1:0]   PE_COL;      // element column
  logic              FETCH_DONE;  // single-cycle completion pulse

  modport master (
    input  ADDR_START, ADDR_RST, ADDRESS, DIMEN, MEM_RDATA,
    output MEM_RDEN, MEM_ADDR, PE_WREN, PE_DATA, PE_ROW, PE_COL, FETCH_DONE
  );

  modport slave (
    output ADDR_START, ADDR_RST, ADDRESS, DIMEN, MEM_RDATA,
    input  MEM_RDEN, MEM_ADDR, PE_WREN, PE_DATA, PE_ROW, PE_COL, FETCH_DONE
  );
endinterface

// File: rtl/fetch_index_gen.sv
// Combinational address and matrix-coordinate generator for one element.
//   base_i : latched matrix base address
//   idx_i  : linear element index (row-major)
//   dim_i  : latched size code
//   addr_o : (base + index) mod 2^17
//   row_o  : index / dim
//   col_o  : index mod dim
module fetch_index_gen
  import simd_pkg::*;
(
  input  logic [ADDR_W-1:0] base_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  dimen_e            dim_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [RC_W-1:0]   row_o,
  output logic [RC_W-1:0]   col_o
);

  // The adder is exactly ADDR_W wide, so the carry-out drops and the
  // address wraps modulo 2^17.
  assign addr_o = base_i + ADDR_W'(idx_i);

  // dim is a power of two: row/col are a plain split of the index bits.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    row_o = '0;
    col_o = '0;
    unique case (dim_i)
      DIM_2X2:   begin row_o = {3'b0, idx_i[1]};   col_o = {3'b0, idx_i[0]};   end
      DIM_4X4:   begin row_o = {2'b0, idx_i[3:2]}; col_o = {2'b0, idx_i[1:0]}; end
      DIM_8X8:   begin row_o = {1'b0, idx_i[5:3]}; col_o = {1'b0, idx_i[2:0]}; end
      DIM_16X16: begin row_o = idx_i[7:4];         col_o = idx_i[3:0];         end
      default:   begin row_o = '0;                 col_o = '0;                 end
    endcase
  end

endmodule

// File: rtl/data_fetch_load.sv
// Matrix fetch unit: on a load request, reads N = dim*dim bytes from data
// memory starting at a latched base address and writes them, one per cycle,
// into the PE matrix buffers with row/column coordinates.
//   CLK, RSTN : clock (rising edge), synchronous active-low reset
//   bus       : data_fetch_load_if.master (request, memory read, PE write)
module data_fetch_load
  import simd_pkg::*;
(
  input logic               CLK,
  input logic               RSTN,
  data_fetch_load_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;        // N-1 of the latched size
  logic [ADDR_W-1:0] base_q, base_d;
  dimen_e            dim_q, dim_d;

  logic [ADDR_W-1:0] addr_hold_q;           // last issued read address
  logic [DATA_W-1:0] data_hold_q;           // last written element value
  logic [RC_W-1:0]   row_q, col_q;          // coordinates of the in-flight read
  logic              wren_q;
  logic              done_q;

  logic [ADDR_W-1:0] gen_addr;
  logic [RC_W-1:0]   gen_row, gen_col;
  logic              rden;
  logic              abort;

  assign abort = bus.ADDR_RST;
  assign rden  = (state_q == ST_READ);

  fetch_index_gen u_index_gen (
    .base_i (base_q),
    .idx_i  (idx_q),
    .dim_i  (dim_q),
    .addr_o (gen_addr),
    .row_o  (gen_row),
    .col_o  (gen_col)
  );

  // Next-state logic. ADDR_RST has priority over everything, including a
  // simultaneous ADDR_START.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    base_d  = base_q;
    dim_d   = dim_q;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.ADDR_START) begin
            state_d = ST_READ;
            base_d  = bus.ADDRESS;
            dim_d   = dimen_e'(bus.DIMEN);
            last_d  = IDX_W'(n_of(dimen_e'(bus.DIMEN)) - 9'd1);
            idx_d   = '0;
          end
        end
        ST_READ: begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == last_q) state_d = ST_DRAIN;
        end
        ST_DRAIN: state_d = ST_DONE;
        // Wait for the control unit to drop its request before re-arming.
        ST_DONE:  if (!bus.ADDR_START) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: reset is sampled on the clock edge only; RSTN is not in the
    // sensitivity list.
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      base_q      <= '0;
      dim_q       <= DIM_2X2;
      addr_hold_q <= '0;
      data_hold_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      wren_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      base_q  <= base_d;
      dim_q   <= dim_d;
      // A read issued in the abort cycle never produces a PE write.
      wren_q  <= rden && !abort;
      done_q  <= (state_q == ST_DRAIN) && !abort;
      if (rden) addr_hold_q <= gen_addr;
      if (rden && !abort) begin
        row_q <= gen_row;
        col_q <= gen_col;
      end
      if (wren_q) data_hold_q <= bus.MEM_RDATA;
    end
  end

  // Address and data track the live value while strobed and hold otherwise.
  assign bus.MEM_RDEN   = rden;
  assign bus.MEM_ADDR   = rden ? gen_addr : addr_hold_q;
  assign bus.PE_WREN    = wren_q;
  assign bus.PE_DATA    = wren_q ? bus.MEM_RDATA : data_hold_q;
  assign bus.PE_ROW     = row_q;
  assign bus.PE_COL     = col_q;
  assign bus.FETCH_DONE = done_q;

endmodule

// File: tb/tb_data_fetch_load.sv
// Scoreboard bench for data_fetch_load. Expected reads, writes and done
// pulses (with their cycle numbers) are queued when a request is driven and
// popped as the DUT produces them. "cyc" counts rising edges; outputs are
// sampled on the falling edge, so the period that follows edge k is seen
// with cyc == k.
module tb_data_fetch_load;
  import simd_pkg::*;

  logic CLK = 1'b0;
  logic RSTN;
  int   cyc = 0;

  data_fetch_load_if bus();

  data_fetch_load dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory contents: mem[0x100 + i] = i + 1, continuing modulo 256.
  function automatic logic [7:0] mem_f(logic [16:0] a);
    logic [16:0] d;
    d = a - 17'h00100 + 17'd1;
    return d[7:0];
  endfunction

  // Synchronous read memory; filler value when not reading.
  always @(posedge CLK) begin
    if (bus.MEM_RDEN === 1'b1) bus.MEM_RDATA <= mem_f(bus.MEM_ADDR);
    else                       bus.MEM_RDATA <= 8'h5A;
  end

  typedef struct {
    int          cyc;
    logic [16:0] addr;
  } rd_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [3:0] row;
    logic [3:0] col;
  } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  done_q[$];
  int  done_cnt = 0;
  int  n_vec    = 0;
  int  n_bad    = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // One falling-edge sample of the DUT outputs against the scoreboard.
  task automatic monitor_step();
    rd_t re;
    wr_t we;
    @(negedge CLK);
    if (RSTN === 1'b1) begin
      if (bus.MEM_RDEN === 1'b1) begin
        if (rd_q.size() == 0) check("rden_unexpected", 32'(bus.MEM_RDEN), 32'd0);
        else begin
          re = rd_q.pop_front();
          check("rd_cycle", 32'(cyc), 32'(re.cyc));
          check("rd_addr", 32'(bus.MEM_ADDR), 32'(re.addr));
        end
      end
      if (bus.PE_WREN === 1'b1) begin
        if (wr_q.size() == 0) check("wren_unexpected", 32'(bus.PE_WREN), 32'd0);
        else begin
          we = wr_q.pop_front();
          check("wr_cycle", 32'(cyc), 32'(we.cyc));
          check("wr_data", 32'(bus.PE_DATA), 32'(we.data));
          check("wr_row", 32'(bus.PE_ROW), 32'(we.row));
          check("wr_col", 32'(bus.PE_COL), 32'(we.col));
        end
      end
      if (bus.FETCH_DONE === 1'b1) begin
        done_cnt++;
        if (done_q.size() == 0) check("done_unexpected", 32'(bus.FETCH_DONE), 32'd0);
        else check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
    end
  endtask

  // Queue the expected traffic of a request first sampled at edge t.
  // Required: reads in cycles t+1..t+N, writes t+2..t+N+1, done t+N+2, which
  // are observed here at cyc t..t+N-1, t+1..t+N and t+N+1.
  task automatic expect_xfer(int t, logic [16:0] base, int code,
                             int nrd, int nwr, bit with_done);
    int  dim;
    rd_t re;
    wr_t we;
    dim = 2 << code;
    for (int i = 0; i < nrd; i++) begin
      re.cyc  = t + i;
      re.addr = base + 17'(i);
      rd_q.push_back(re);
    end
    for (int i = 0; i < nwr; i++) begin
      we.cyc  = t + 1 + i;
      we.data = mem_f(base + 17'(i));
      we.row  = 4'(i / dim);
      we.col  = 4'(i % dim);
      wr_q.push_back(we);
    end
    if (with_done) done_q.push_back(t + dim * dim + 1);
  endtask

  task automatic start(logic [16:0] base, int code, output int t);
    bus.ADDRESS    = base;
    bus.DIMEN      = 2'(code);
    bus.ADDR_START = 1'b1;
    t = cyc + 1;
  endtask

  task automatic wait_done(int budget);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == d0; k++) tick();
    check("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_drained(string tag);
    check({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    check({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
    check({tag, "_done_left"}, 32'(done_q.size()), 32'd0);
  endtask

  // Complete transfer; optionally keep ADDR_START high after FETCH_DONE.
  task automatic full_xfer(string tag, logic [16:0] base, int code, int hold);
    int t;
    int n;
    n = (2 << code) * (2 << code);
    start(base, code, t);
    expect_xfer(t, base, code, n, n, 1'b1);
    wait_done(n + 20);
    for (int j = 0; j < hold; j++) begin
      tick();
      check({tag, "_hold_done"}, 32'(bus.FETCH_DONE), 32'd0);
      check({tag, "_hold_rden"}, 32'(bus.MEM_RDEN), 32'd0);
    end
    bus.ADDR_START = 1'b0;
    tick();
    tick();
    check({tag, "_idle_rden"}, 32'(bus.MEM_RDEN), 32'd0);
    check_drained(tag);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rden"}, 32'(bus.MEM_RDEN), 32'd0);
    check({tag, "_addr"}, 32'(bus.MEM_ADDR), 32'd0);
    check({tag, "_wren"}, 32'(bus.PE_WREN), 32'd0);
    check({tag, "_data"}, 32'(bus.PE_DATA), 32'd0);
    check({tag, "_row"}, 32'(bus.PE_ROW), 32'd0);
    check({tag, "_col"}, 32'(bus.PE_COL), 32'd0);
    check({tag, "_done"}, 32'(bus.FETCH_DONE), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int d0;
    RSTN           = 1'b0;
    bus.ADDR_START = 1'b0;
    bus.ADDR_RST   = 1'b0;
    bus.ADDRESS    = '0;
    bus.DIMEN      = 2'd0;

    fork
      forever monitor_step();
    join_none

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset");
    RSTN = 1'b1;
    tick();

    // 2x2 at 0x00100: data 1..4 at (0,0),(0,1),(1,0),(1,1).
    full_xfer("t1", 17'h00100, 0, 0);

    // 16x16 at 0x1FF80: address wraps 0x1FFFF -> 0x00000 after index 127.
    full_xfer("t2", 17'h1FF80, 3, 0);

    // 4x4 aborted after 5 reads: the 5th read is in flight and discarded.
    d0 = done_cnt;
    start(17'h00400, 1, t);
    expect_xfer(t, 17'h00400, 1, 5, 4, 1'b0);
    repeat (5) tick();
    bus.ADDR_RST   = 1'b1;
    bus.ADDR_START = 1'b0;
    tick();
    bus.ADDR_RST = 1'b0;
    check("t3_rden_off", 32'(bus.MEM_RDEN), 32'd0);
    check("t3_wren_off", 32'(bus.PE_WREN), 32'd0);
    check("t3_addr_hold", 32'(bus.MEM_ADDR), 32'(17'h00404));
    check("t3_data_hold", 32'(bus.PE_DATA), 32'(mem_f(17'h00403)));
    check("t3_row_hold", 32'(bus.PE_ROW), 32'd0);
    check("t3_col_hold", 32'(bus.PE_COL), 32'd3);
    repeat (20) tick();
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);
    check_drained("t3");

    // 8x8 with ADDR_START held 3 cycles past FETCH_DONE.
    full_xfer("t4", 17'h02345, 2, 3);

    // START+RST together in IDLE: treated as RST only.
    bus.ADDRESS    = 17'h0A000;
    bus.DIMEN      = 2'd1;
    bus.ADDR_START = 1'b1;
    bus.ADDR_RST   = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("t5_both_rden", 32'(bus.MEM_RDEN), 32'd0);
    end
    // Release RST with START still high; then change ADDRESS/DIMEN mid-run.
    bus.ADDR_RST = 1'b0;
    t = cyc + 1;
    expect_xfer(t, 17'h0A000, 1, 16, 16, 1'b1);
    repeat (3) tick();
    bus.ADDRESS = 17'h01234;
    bus.DIMEN   = 2'd3;
    wait_done(40);
    bus.ADDR_START = 1'b0;
    tick();
    tick();
    check_drained("t5");

    // Reset in the middle of an 8x8 transfer.
    d0 = done_cnt;
    start(17'h00800, 2, t);
    expect_xfer(t, 17'h00800, 2, 6, 5, 1'b0);
    repeat (6) tick();
    RSTN           = 1'b0;
    bus.ADDR_START = 1'b0;
    tick();
    check_all_zero("midrst");
    RSTN = 1'b1;
    repeat (10) tick();
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check_drained("midrst");

    // Recovery after reset.
    full_xfer("t6", 17'h00100, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_fetch_load.md
DATA_FETCH_LOAD -- requirements
Module: data_fetch_load

Interface
REQ-001 SHALL have port CLK, input, 1: system clock; all logic on rising edge.
REQ-002 SHALL have port RSTN, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port ADDR_START, input, 1: load request, held high by the control unit until it sees FETCH_DONE.
REQ-004 SHALL have port ADDR_RST, input, 1: abort/clear pulse from the control unit.
REQ-005 SHALL have port ADDRESS, input, 17: matrix base address in data memory.
REQ-006 SHALL have port DIMEN, input, 2: matrix size code; 0=2x2, 1=4x4, 2=8x8, 3=16x16.
REQ-007 SHALL have port MEM_RDEN, output, 1: data-memory read enable.
REQ-008 SHALL have port MEM_ADDR, output, 17: data-memory read address.
REQ-009 SHALL have port MEM_RDATA, input, 8: read data, valid exactly one cycle after MEM_RDEN.
REQ-010 SHALL have port PE_WREN, output, 1: element write strobe to PE matrix buffers.
REQ-011 SHALL have port PE_DATA, output, 8: element value.
REQ-012 SHALL have port PE_ROW, output, 4: element row index.
REQ-013 SHALL have port PE_COL, output, 4: element column index.
REQ-014 SHALL have port FETCH_DONE, output, 1: single-cycle completion pulse to the control unit.

Function
REQ-015 SHALL implement an FSM with states IDLE, READ, DRAIN, DONE.
REQ-016 In IDLE, ADDR_START=1 with ADDR_RST=0 SHALL latch ADDRESS as base, latch N = dim*dim (dim = 2,4,8,16 per DIMEN), clear index, and enter READ.
REQ-017 ADDRESS and DIMEN changes after latching SHALL be ignored until the next IDLE->READ transition.
REQ-018 In READ, each cycle SHALL drive MEM_RDEN=1 and MEM_ADDR = (base + index) mod 2^17, then increment index; after issuing index N-1 the FSM SHALL enter DRAIN.
REQ-019 PE_WREN SHALL be 1 exactly one cycle after each MEM_RDEN, with PE_DATA=MEM_RDATA, PE_ROW=index/dim, PE_COL=index mod dim for the index issued in the previous cycle.
REQ-020 DRAIN SHALL last one cycle, emitting the final PE_WREN, then enter DONE.
REQ-021 FETCH_DONE SHALL be 1 for exactly the first cycle in DONE.
REQ-022 Latency: with ADDR_START first sampled at edge t, MEM_RDEN SHALL be high during cycles t+1..t+N, PE_WREN during t+2..t+N+1, and FETCH_DONE during t+N+2.
REQ-023 DONE SHALL return to IDLE when ADDR_RST=1 or ADDR_START=0; while it is held there, FETCH_DONE SHALL be 0.
REQ-024 ADDR_RST=1 in any state SHALL force IDLE next cycle, clear index, deassert MEM_RDEN/PE_WREN, and suppress FETCH_DONE; an in-flight read's data SHALL be discarded.
REQ-025 Simultaneous ADDR_START=1 and ADDR_RST=1 SHALL be treated as ADDR_RST only.
REQ-026 ADDR_START falling during READ/DRAIN SHALL be ignored; the transfer SHALL complete.
REQ-027 When not strobed, MEM_ADDR, PE_DATA, PE_ROW and PE_COL SHALL hold their last values.

Reset
REQ-028 RSTN=0 at a clock edge SHALL set state=IDLE, index=0, base=0, MEM_RDEN=0, MEM_ADDR=0, PE_WREN=0, PE_DATA=0, PE_ROW=0, PE_COL=0, FETCH_DONE=0.
REQ-029 Reset mid-transfer SHALL behave as REQ-028 with no FETCH_DONE.

Structure
REQ-030 The DIMEN size-code enum, the dim/N lookup, and the 17-bit address width constant SHALL reside in shared package simd_pkg.
REQ-031 Index-to-(row,col) and address generation SHALL be one sub-module, fetch_index_gen; the FSM and pipeline register SHALL live in data_fetch_load.

Verification
REQ-032 Directed test 1: DIMEN=0, ADDRESS=0x00100, memory[i]=i+1. Required: 4 reads at 0x00100..0x00103; PE_WREN data 1..4 at (0,0),(0,1),(1,0),(1,1); FETCH_DONE at t+6.
REQ-033 Directed test 2: DIMEN=3, ADDRESS=0x1FF80. Required: 256 reads with MEM_ADDR wrapping 0x1FFFF->0x00000 after index 127; last write at (15,15); FETCH_DONE at t+258.
REQ-034 Directed test 3: DIMEN=1; pulse ADDR_RST after 5 reads. Required: IDLE next cycle, no further PE_WREN, FETCH_DONE never asserted.
REQ-035 Directed test 4: DIMEN=2; hold ADDR_START high for 3 cycles after FETCH_DONE. Required: FETCH_DONE high 1 cycle only and no new transfer; return to IDLE on ADDR_START=0.
REQ-036 Directed test 5: ADDR_START and ADDR_RST high together in IDLE. Required: no MEM_RDEN. Then change ADDRESS/DIMEN mid-transfer. Required: original base and size used.
